// File: rtl/if_id_stage_pkg.sv
// Shared types and constants for the fetch stage.
// Opcode set, NOP word and the rt-usage decoder.
package if_id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_MUL   = 6'b011100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic uses_rt(input logic [5:0] op);
    logic r;
    r = 1'b0;
    unique case (op)
      OP_RTYPE, OP_MUL,
      OP_BEQ, OP_BNE,
      OP_SB, OP_SH, OP_SW: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory bus between fetch and imem.
// Read is combinational within the cycle.
interface if_id_stage_if;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Data;

  modport master (
    output Imem_Addr,
    input  Imem_Data
  );

  modport slave (
    input  Imem_Addr,
    output Imem_Data
  );
endinterface

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard check against the load sitting in EX.
// Purely combinational.
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == rs);
  assign rt_hit = uses_rt(opcode) & (ex_rt == rt);

  assign load_use = ex_mem_read
                  & (ex_rt != 5'd0)
                  & (rs_hit | rt_hit);

endmodule

// File: rtl/if_id_stage.sv
// PC, IF/ID register, redirect/stall control
// and saturating debug counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  if_id_stage_if.master    imem,
  input  logic             Redirect,
  input  logic [31:0]      Redirect_Target,
  input  logic             ID_EX_Mem_Read,
  input  logic [4:0]       ID_EX_Rt,
  output logic [31:0]      IF_ID_Instruction,
  output logic [31:0]      IF_ID_PC_Plus4,
  output logic             Bubble,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  if_id_t      if_id;
  logic        load_use;

  assign pc_plus4       = pc + 32'd4;
  assign imem.Imem_Addr = pc;

  assign IF_ID_Instruction = if_id.instr;
  assign IF_ID_PC_Plus4    = if_id.pc_plus4;

  hazard_detect u_hazard (
    .opcode      (if_id.instr[31:26]),
    .rs          (if_id.instr[25:21]),
    .rt          (if_id.instr[20:16]),
    .ex_mem_read (ID_EX_Mem_Read),
    .ex_rt       (ID_EX_Rt),
    .load_use    (load_use)
  );

  assign Bubble = Rst | Redirect | load_use;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc          <= PC_RESET;
      if_id       <= '{instr: NOP, pc_plus4: 32'd0};
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else if (Redirect) begin
      // a load-use seen in the same cycle dies with the flush
      pc    <= {Redirect_Target[31:2], 2'b00};
      if_id <= '{instr: NOP, pc_plus4: 32'd0};
      if (Flush_Count != '1)
        Flush_Count <= Flush_Count + ONE;
    end else if (load_use) begin
      if (Stall_Count != '1)
        Stall_Count <= Stall_Count + ONE;
    end else begin
      pc    <= pc_plus4;
      if_id <= '{instr: imem.Imem_Data,
                 pc_plus4: pc_plus4};
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage.
// Narrow counters so saturation is reachable.
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  localparam int CW = 4;

  logic          Clk;
  logic          Rst;
  logic          Redirect;
  logic [31:0]   Redirect_Target;
  logic          ID_EX_Mem_Read;
  logic [4:0]    ID_EX_Rt;
  logic [31:0]   IF_ID_Instruction;
  logic [31:0]   IF_ID_PC_Plus4;
  logic          Bubble;
  logic [CW-1:0] Stall_Count;
  logic [CW-1:0] Flush_Count;

  int total = 0;
  int bad   = 0;

  if_id_stage_if imem ();

  if_id_stage #(
    .PC_RESET (32'h0000_0000),
    .CNT_W    (CW)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .imem              (imem.master),
    .Redirect          (Redirect),
    .Redirect_Target   (Redirect_Target),
    .ID_EX_Mem_Read    (ID_EX_Mem_Read),
    .ID_EX_Rt          (ID_EX_Rt),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PC_Plus4    (IF_ID_PC_Plus4),
    .Bubble            (Bubble),
    .Stall_Count       (Stall_Count),
    .Flush_Count       (Flush_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst             = 1'b1;
    Redirect        = 1'b0;
    Redirect_Target = 32'h0;
    ID_EX_Mem_Read  = 1'b0;
    ID_EX_Rt        = 5'd0;
    imem.Imem_Data  = 32'h2008_0005;

    step();
    step();
    chk("rst_bubble", {31'd0, Bubble}, 32'd1);
    chk("rst_ifid", IF_ID_Instruction, 32'h0);
    chk("rst_p4", IF_ID_PC_Plus4, 32'h0);
    chk("rst_pc", imem.Imem_Addr, 32'h0);
    chk("rst_stall", {28'd0, Stall_Count}, 32'd0);
    chk("rst_flush", {28'd0, Flush_Count}, 32'd0);

    Rst = 1'b0;
    #1;
    chk("rel_bubble", {31'd0, Bubble}, 32'd0);
    step();
    chk("first_ifid", IF_ID_Instruction, 32'h2008_0005);
    chk("first_p4", IF_ID_PC_Plus4, 32'd4);
    chk("first_pc", imem.Imem_Addr, 32'd4);

    for (int i = 0; i < 4; i++) begin
      imem.Imem_Data = 32'h2400_0000 | (i + 1);
      chk("line_pc", imem.Imem_Addr, 32'd4 + 32'd4 * i);
      step();
      chk("line_ifid", IF_ID_Instruction,
          32'h2400_0000 | (i + 1));
      chk("line_p4", IF_ID_PC_Plus4, 32'd8 + 32'd4 * i);
    end
    chk("line_end_pc", imem.Imem_Addr, 32'd20);

    imem.Imem_Data = 32'h0044_1820;
    step();
    chk("lu_ifid", IF_ID_Instruction, 32'h0044_1820);
    chk("lu_pc0", imem.Imem_Addr, 32'd24);

    imem.Imem_Data = 32'h20c5_0001;
    ID_EX_Mem_Read = 1'b1;
    ID_EX_Rt       = 5'd2;
    #1;
    chk("lu_bubble", {31'd0, Bubble}, 32'd1);
    step();
    chk("lu_pc_hold", imem.Imem_Addr, 32'd24);
    chk("lu_ifid_hold", IF_ID_Instruction, 32'h0044_1820);
    chk("lu_stall1", {28'd0, Stall_Count}, 32'd1);

    ID_EX_Rt = 5'd0;
    #1;
    chk("lu_rt0", {31'd0, Bubble}, 32'd0);
    ID_EX_Rt = 5'd4;
    #1;
    chk("lu_rt_rtype", {31'd0, Bubble}, 32'd1);

    ID_EX_Mem_Read = 1'b0;
    #1;
    step();
    chk("addi_ifid", IF_ID_Instruction, 32'h20c5_0001);
    chk("addi_pc", imem.Imem_Addr, 32'd28);
    chk("addi_stall", {28'd0, Stall_Count}, 32'd1);

    ID_EX_Mem_Read = 1'b1;
    ID_EX_Rt       = 5'd5;
    #1;
    chk("addi_rt_only", {31'd0, Bubble}, 32'd0);
    ID_EX_Rt = 5'd6;
    #1;
    chk("addi_rs_hit", {31'd0, Bubble}, 32'd1);

    Redirect        = 1'b1;
    Redirect_Target = 32'h0000_0043;
    #1;
    chk("rd_bubble", {31'd0, Bubble}, 32'd1);
    step();
    chk("rd_pc", imem.Imem_Addr, 32'h40);
    chk("rd_ifid", IF_ID_Instruction, 32'h0);
    chk("rd_p4", IF_ID_PC_Plus4, 32'h0);
    chk("rd_flush", {28'd0, Flush_Count}, 32'd1);
    chk("rd_stall", {28'd0, Stall_Count}, 32'd1);

    ID_EX_Mem_Read  = 1'b0;
    Redirect_Target = 32'hffff_ffff;
    step();
    chk("wrap_rd_pc", imem.Imem_Addr, 32'hffff_fffc);
    chk("wrap_flush", {28'd0, Flush_Count}, 32'd2);

    Redirect       = 1'b0;
    imem.Imem_Data = 32'h2008_0005;
    step();
    chk("wrap_pc", imem.Imem_Addr, 32'h0);
    chk("wrap_ifid", IF_ID_Instruction, 32'h2008_0005);
    chk("wrap_p4", IF_ID_PC_Plus4, 32'h0);

    imem.Imem_Data = 32'h0044_1820;
    step();
    ID_EX_Mem_Read = 1'b1;
    ID_EX_Rt       = 5'd2;
    repeat (20) step();
    chk("sat_stall", {28'd0, Stall_Count}, 32'hf);
    chk("sat_pc", imem.Imem_Addr, 32'd4);
    chk("sat_ifid", IF_ID_Instruction, 32'h0044_1820);

    Rst = 1'b1;
    step();
    chk("mid_rst_pc", imem.Imem_Addr, 32'h0);
    chk("mid_rst_ifid", IF_ID_Instruction, 32'h0);
    chk("mid_rst_stall", {28'd0, Stall_Count}, 32'd0);
    chk("mid_rst_flush", {28'd0, Flush_Count}, 32'd0);
    chk("mid_rst_bub", {31'd0, Bubble}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
